// File: rtl/rsa_modexp_core.sv
// Modular exponentiation C = P^E mod M. A single bit-serial Montgomery multiplier
// is reused for every step of a left-to-right square-and-multiply sequence.
module rsa_modexp_core #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 ena,
  input  logic                 clear,
  input  logic                 start,
  input  logic [WIDTH-1:0]     P,
  input  logic [EXP_WIDTH-1:0] E,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Const,
  output logic [WIDTH-1:0]     C,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int N  = WIDTH + 2;
  localparam int CW = $clog2(N + 1);
  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N);
  localparam logic [IW-1:0] IDX_TOP  = IW'(EXP_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, PRE_P, PRE_X, SQR, MUL, POST, FIX, DONE
  } state_t;

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [IW-1:0]        idx_reg;
  logic [EXP_WIDTH-1:0] e_reg;
  logic [WIDTH-1:0]     m_reg;
  logic [WIDTH-1:0]     p_reg;
  logic [WIDTH-1:0]     k_reg;
  logic [N-1:0]         pm_reg;
  logic [N-1:0]         xm_reg;
  logic [N-1:0]         a_reg;
  logic [N-1:0]         b_reg;
  logic [N:0]           acc_reg;
  logic [WIDTH-1:0]     c_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 err_reg;

  logic [N+1:0]         sum_raw;
  logic [N:0]           m_half;
  logic [N:0]           acc_next;
  logic [N-1:0]         mp_res;
  logic [N-1:0]         op_a;
  logic [N-1:0]         op_b;
  logic                 x_ge_m;
  logic [WIDTH-1:0]     c_next;

  always_comb begin
    sum_raw  = {1'b0, acc_reg} + (a_reg[0] ? {2'b00, b_reg} : '0);
    // For odd sum and odd M, (sum + M) / 2 == (sum >> 1) + (M >> 1) + 1.
    m_half   = (N+1)'(m_reg[WIDTH-1:1]) + (N+1)'(1);
    acc_next = sum_raw[N+1:1] + (sum_raw[0] ? m_half : '0);
    mp_res   = acc_next[N-1:0];

    op_a = '0;
    op_b = '0;
    case (state_reg)
      PRE_P: begin op_a = {2'b00, p_reg}; op_b = {2'b00, k_reg}; end
      PRE_X: begin op_a = N'(1);          op_b = {2'b00, k_reg}; end
      SQR:   begin op_a = xm_reg;         op_b = xm_reg;         end
      MUL:   begin op_a = xm_reg;         op_b = pm_reg;         end
      POST:  begin op_a = xm_reg;         op_b = N'(1);          end
      default: ;
    endcase

    x_ge_m = (xm_reg >= {2'b00, m_reg});
    c_next = x_ge_m ? (xm_reg[WIDTH-1:0] - m_reg) : xm_reg[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      e_reg     <= '0;
      m_reg     <= '0;
      p_reg     <= '0;
      k_reg     <= '0;
      pm_reg    <= '0;
      xm_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      c_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        busy_reg  <= 1'b0;
        done_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            done_reg <= 1'b0;
            if (start) begin
              p_reg   <= P;
              e_reg   <= E;
              m_reg   <= M;
              k_reg   <= Const;
              cnt_reg <= '0;
              // An even modulus has no Montgomery inverse: report and finish at once.
              if (!M[0]) begin
                c_reg     <= '0;
                err_reg   <= 1'b1;
                done_reg  <= 1'b1;
                state_reg <= DONE;
              end else begin
                err_reg   <= 1'b0;
                busy_reg  <= 1'b1;
                state_reg <= PRE_P;
              end
            end
          end
          PRE_P, PRE_X, SQR, MUL, POST: begin
            if (cnt_reg == '0) begin
              a_reg   <= op_a;
              b_reg   <= op_b;
              acc_reg <= '0;
              cnt_reg <= CW'(1);
            end else begin
              acc_reg <= acc_next;
              a_reg   <= a_reg >> 1;
              if (cnt_reg == CNT_LAST) begin
                cnt_reg <= '0;
                case (state_reg)
                  PRE_P: begin
                    pm_reg    <= mp_res;
                    state_reg <= PRE_X;
                  end
                  PRE_X: begin
                    xm_reg    <= mp_res;
                    idx_reg   <= IDX_TOP;
                    state_reg <= SQR;
                  end
                  SQR: begin
                    xm_reg <= mp_res;
                    if (e_reg[idx_reg]) begin
                      state_reg <= MUL;
                    end else if (idx_reg == '0) begin
                      state_reg <= POST;
                    end else begin
                      idx_reg   <= idx_reg - 1'b1;
                      state_reg <= SQR;
                    end
                  end
                  MUL: begin
                    xm_reg <= mp_res;
                    if (idx_reg == '0) begin
                      state_reg <= POST;
                    end else begin
                      idx_reg   <= idx_reg - 1'b1;
                      state_reg <= SQR;
                    end
                  end
                  default: begin
                    xm_reg    <= mp_res;
                    state_reg <= FIX;
                  end
                endcase
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
          end
          FIX: begin
            c_reg     <= c_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end
          DONE: begin
            done_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign C    = c_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed and table-driven checks of rsa_modexp_core at 8 bits, plus a small
// randomized 16-bit regression against a software pow() model.
module tb_rsa_modexp_core;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        ena = 1'b1;
  logic        clear = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  P8 = '0, E8 = '0, M8 = '0, K8 = '0;
  logic [7:0]  C8;
  logic        busy8, done8, err8;

  logic        start16 = 1'b0;
  logic [15:0] P16 = '0, E16 = '0, M16 = '0, K16 = '0;
  logic [15:0] C16;
  logic        busy16, done16, err16;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  last_c8 = '0;

  always #5 clk = ~clk;

  rsa_modexp_core #(.WIDTH(8), .EXP_WIDTH(8)) u_dut8 (
    .clk(clk), .rstb(rstb), .ena(ena), .clear(clear), .start(start8),
    .P(P8), .E(E8), .M(M8), .Const(K8),
    .C(C8), .busy(busy8), .done(done8), .err(err8)
  );

  rsa_modexp_core #(.WIDTH(16), .EXP_WIDTH(16)) u_dut16 (
    .clk(clk), .rstb(rstb), .ena(ena), .clear(clear), .start(start16),
    .P(P16), .E(E16), .M(M16), .Const(K16),
    .C(C16), .busy(busy16), .done(done16), .err(err16)
  );

  typedef struct {
    logic [7:0] p;
    logic [7:0] e;
    logic [7:0] m;
    logic [7:0] k;
    logic [7:0] c;
    logic       err;
    int         lat;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Runs one 8-bit operation; optionally randomizes ena and pokes start mid-run.
  task automatic do_op8(input vec_t v, input bit rnd_ena, input int poke_at, input string nm);
    int   lat;
    int   guard;
    int   bad_busy;
    int   bad_hold;
    logic en_now;
    P8 = v.p; E8 = v.e; M8 = v.m; K8 = v.k;
    start8 = 1'b1;
    ena = 1'b1;
    step();
    start8 = 1'b0;
    P8 = ~v.p; E8 = ~v.e; K8 = ~v.k;
    lat = 0; guard = 0; bad_busy = 0; bad_hold = 0;
    while (!done8 && guard < 4000) begin
      if (!busy8) bad_busy++;
      if (C8 !== last_c8) bad_hold++;
      start8 = (poke_at > 0 && lat >= poke_at && lat < poke_at + 3);
      en_now = rnd_ena ? 1'($urandom_range(0, 1)) : 1'b1;
      ena = en_now;
      step();
      guard++;
      if (en_now) lat++;
    end
    start8 = 1'b0;
    ena = 1'b1;
    check({nm, " done_seen"}, done8, 1);
    check({nm, " latency"}, lat, v.lat);
    check({nm, " C"}, C8, v.c);
    check({nm, " err"}, err8, v.err);
    check({nm, " busy_at_done"}, busy8, 0);
    check({nm, " busy_low_while_running"}, bad_busy, 0);
    check({nm, " C_held_while_running"}, bad_hold, 0);
    $display("op %s: P=%0d E=%0d M=%0d -> C=%0d err=%0d latency=%0d", nm, v.p, v.e, v.m, C8, err8, lat);
    last_c8 = v.c;
    step();
    check({nm, " done_one_cycle"}, done8, 0);
  endtask

  function automatic longint mod_pow(input longint b, input longint e, input longint m);
    longint r;
    longint bb;
    r = 1 % m;
    bb = b % m;
    for (int i = 15; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * bb) % m;
    end
    return r;
  endfunction

  function automatic longint r2_mod(input longint m);
    longint r;
    r = 1 % m;
    for (int i = 0; i < 36; i++) r = (r * 2) % m;
    return r;
  endfunction

  task automatic do_op16(input int idx);
    longint m, p, e, k, c_exp;
    int     lat;
    int     lat_exp;
    m = longint'($urandom_range(1, 65535) | 1);
    p = longint'($urandom) % m;
    e = longint'($urandom_range(0, 65535));
    k = r2_mod(m);
    c_exp = mod_pow(p, e, m);
    lat_exp = (3 + 16 + $countones(e[15:0])) * 19 + 1;
    P16 = p[15:0]; E16 = e[15:0]; M16 = m[15:0]; K16 = k[15:0];
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 2000) begin
      step();
      lat++;
    end
    check($sformatf("rand16[%0d] latency", idx), lat, lat_exp);
    check($sformatf("rand16[%0d] C", idx), C16, c_exp);
    $display("op rand16[%0d]: P=%0d E=%0d M=%0d -> C=%0d latency=%0d", idx, p, e, m, C16, lat);
    step();
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v_std;
    int   lat;
    int   bad;

    vecs[0] = '{p: 8'd88,  e: 8'd7,   m: 8'd187, k: 8'd67, c: 8'd11,  err: 1'b0, lat: 155};
    vecs[1] = '{p: 8'd11,  e: 8'd23,  m: 8'd187, k: 8'd67, c: 8'd88,  err: 1'b0, lat: 166};
    vecs[2] = '{p: 8'd0,   e: 8'd0,   m: 8'd186, k: 8'd67, c: 8'd0,   err: 1'b1, lat: 0};
    vecs[3] = '{p: 8'd50,  e: 8'd0,   m: 8'd187, k: 8'd67, c: 8'd1,   err: 1'b0, lat: 122};
    vecs[4] = '{p: 8'd0,   e: 8'd5,   m: 8'd1,   k: 8'd0,  c: 8'd0,   err: 1'b0, lat: 144};
    vecs[5] = '{p: 8'd2,   e: 8'd255, m: 8'd187, k: 8'd67, c: 8'd43,  err: 1'b0, lat: 210};
    vecs[6] = '{p: 8'd186, e: 8'd3,   m: 8'd187, k: 8'd67, c: 8'd186, err: 1'b0, lat: 144};
    vecs[7] = '{p: 8'd88,  e: 8'd7,   m: 8'd187, k: 8'd67, c: 8'd11,  err: 1'b0, lat: 155};
    v_std = vecs[0];

    // Reset state, both during and after reset.
    repeat (3) step();
    check("reset C", C8, 0);
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset err", err8, 0);
    rstb = 1'b1;
    step();
    check("post_reset busy", busy8, 0);
    check("post_reset done", done8, 0);

    for (int i = 0; i < 8; i++) begin
      do_op8(vecs[i], 1'b0, 0, $sformatf("vec[%0d]", i));
    end

    // start pulsed while busy must not disturb the running operation.
    do_op8(v_std, 1'b0, 20, "start_while_busy");

    // Randomly gated ena: latency counts enabled cycles only.
    do_op8(v_std, 1'b1, 0, "ena_random");

    // clear at cycle 40, asserted together with start: abort wins.
    P8 = 8'd88; E8 = 8'd7; M8 = 8'd187; K8 = 8'd67;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (40) step();
    check("clear pre busy", busy8, 1);
    clear = 1'b1;
    start8 = 1'b1;
    step();
    clear = 1'b0;
    start8 = 1'b0;
    check("clear busy", busy8, 0);
    check("clear done", done8, 0);
    check("clear C", C8, last_c8);
    bad = 0;
    repeat (20) begin
      step();
      if (busy8 || done8) bad++;
    end
    check("clear stays idle", bad, 0);
    $display("op clear_abort: busy=%0d done=%0d C=%0d", busy8, done8, C8);

    // start during the DONE cycle is ignored.
    P8 = 8'd50; E8 = 8'd0; M8 = 8'd187; K8 = 8'd67;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 1000) begin
      step();
      lat++;
    end
    check("done_start latency", lat, 122);
    check("done_start C", C8, 1);
    last_c8 = 8'd1;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    check("start_in_done ignored busy", busy8, 0);
    check("start_in_done ignored done", done8, 0);
    $display("op start_in_done: C=%0d busy=%0d", C8, busy8);

    // start held high: a new operation begins as soon as IDLE is re-entered.
    P8 = 8'd88; E8 = 8'd7; M8 = 8'd187; K8 = 8'd67;
    start8 = 1'b1;
    step();
    lat = 0;
    while (!done8 && lat < 1000) begin
      step();
      lat++;
    end
    check("held latency", lat, 155);
    check("held C", C8, 11);
    step();
    check("held idle busy", busy8, 0);
    step();
    check("held restart busy", busy8, 1);
    start8 = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("held abort busy", busy8, 0);
    last_c8 = 8'd11;
    $display("op held_start: C=%0d restarted and aborted", C8);

    // Asynchronous reset in the middle of an operation.
    P8 = 8'd11; E8 = 8'd23; M8 = 8'd187; K8 = 8'd67;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    repeat (60) step();
    check("midreset pre busy", busy8, 1);
    #2;
    rstb = 1'b0;
    #1;
    check("midreset C", C8, 0);
    check("midreset busy", busy8, 0);
    check("midreset done", done8, 0);
    check("midreset err", err8, 0);
    step();
    step();
    rstb = 1'b1;
    step();
    last_c8 = 8'd0;
    $display("op mid_reset: C=%0d busy=%0d", C8, busy8);
    do_op8(v_std, 1'b0, 0, "after_reset");

    for (int i = 0; i < 6; i++) begin
      do_op16(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
